// File: rtl/hud_track_meter_pkg.sv
// Shared types, colours and the saturation helper for the HUD progress column.
// Pure declarations, no logic; no flow control.
package hud_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        LOW   = 2'd1,
        EMPTY = 2'd2
    } fuel_state_t;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_ISSUE = 2'd1,
        SEQ_WAIT  = 2'd2
    } seq_state_t;

    localparam logic [7:0] MASK    = 8'h62;
    localparam logic [7:0] BAR     = 8'h6d;
    localparam logic [7:0] ALERT   = 8'he0;
    localparam logic [7:0] MARKER0 = 8'he4;
    localparam logic [7:0] MARKERN = 8'h1f;

    localparam logic [13:0] SCORE_CEIL = 14'd9999;

    function automatic logic [13:0] sat_to(input logic [15:0] v, input logic [13:0] lim);
        return (v > {2'b00, lim}) ? lim : v[13:0];
    endfunction

endpackage

// File: rtl/hud_track_meter_seq_divider.sv
// 64/32 restoring divider, one quotient bit per cycle: 32 steps after start, done pulses for one cycle.
// No backpressure; abort drops the run and suppresses done. Caller guarantees dividend[63:32] < divisor.
module seq_divider (
    input  logic        clk,
    input  logic        resetN,
    input  logic        start,
    input  logic        abort,
    input  logic [63:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic        done
);

    logic        busy_q;
    logic [4:0]  cnt_q;
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] div_q;
    logic        done_q;
    logic [32:0] shifted;
    logic [32:0] diff;

    // diff[32] set means the trial subtraction went negative (restore)
    assign shifted = {rem_q, quo_q[31]};
    assign diff    = shifted - {1'b0, div_q};

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            div_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                busy_q <= 1'b0;
            end else if (start) begin
                busy_q <= 1'b1;
                cnt_q  <= '0;
                rem_q  <= dividend[63:32];
                quo_q  <= dividend[31:0];
                div_q  <= divisor;
            end else if (busy_q) begin
                rem_q <= diff[32] ? shifted[31:0] : diff[31:0];
                quo_q <= {quo_q[30:0], ~diff[32]};
                cnt_q <= cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign quotient = quo_q;
    assign done     = done_q;

endmodule

// File: rtl/hud_track_meter.sv
// Race-progress column: N car markers, score/fuel counters, low-fuel blink FSM; colour 2 cycles after x/y.
// No backpressure: one pixel per cycle, marker positions refresh once per frame.
module hud_track_meter
    import hud_pkg::*;
#(
    parameter int N_MARKERS    = 2,
    parameter int BAR_X        = 0,
    parameter int BAR_W        = 32,
    parameter int BAR_TOP      = 16,
    parameter int BAR_BOTTOM   = 480,
    parameter int MARKER_H     = 16,
    parameter int FUEL_MAX     = 100,
    parameter int FUEL_PICKUP  = 5,
    parameter int PICKUP_SCORE = 100,
    parameter int FUEL_LOW     = 20,
    parameter int SCORE_PERIOD = 16,
    parameter int FUEL_PERIOD  = 64,
    parameter int BLINK_PERIOD = 16
) (
    input  logic                           clk,
    input  logic                           resetN,
    input  logic                           frame_start,
    input  logic                           game_active,
    input  logic [10:0]                    requested_x,
    input  logic [10:0]                    requested_y,
    input  logic [9:0]                     player_speed,
    input  logic                           fuel_pickup,
    input  logic [N_MARKERS-1:0][31:0]     distances,
    input  logic [31:0]                    track_length,
    output logic [7:0]                     output_color,
    output logic [N_MARKERS-1:0][10:0]     marker_y,
    output logic [13:0]                    score_val,
    output logic [13:0]                    fuel_val,
    output logic                           fuel_empty
);

    localparam int          IDX_W     = (N_MARKERS > 1) ? $clog2(N_MARKERS) : 1;
    localparam int          BLINK_BIT = $clog2(BLINK_PERIOD);
    localparam logic [31:0] SPAN_U    = 32'(BAR_BOTTOM - BAR_TOP - MARKER_H);
    localparam logic [10:0] Y_REST    = 11'(BAR_BOTTOM - MARKER_H);
    localparam logic [10:0] Y_TOP     = 11'(BAR_TOP);

    // ---------------- frame counter, score, fuel ----------------
    logic [15:0] frame_cnt_q, frame_cnt_d, frame_cnt_inc;
    logic [13:0] score_q, score_d, fuel_q, fuel_d, fuel_mid;
    logic [15:0] score_sum, fuel_up;
    logic        score_tick, fuel_tick, pickup_ok, moving;
    fuel_state_t state_q, state_d;

    assign frame_cnt_inc = frame_cnt_q + 16'd1;
    assign frame_cnt_d   = frame_start ? frame_cnt_inc : frame_cnt_q;
    assign score_tick    = frame_start && ((frame_cnt_inc & 16'(SCORE_PERIOD - 1)) == 16'd0);
    assign fuel_tick     = frame_start && ((frame_cnt_inc & 16'(FUEL_PERIOD - 1)) == 16'd0);
    assign pickup_ok     = fuel_pickup && (state_q != EMPTY);
    assign moving        = (player_speed != 10'd0);

    always_comb begin
        score_sum = {2'b00, score_q};
        if (game_active && score_tick && moving) score_sum = score_sum + 16'(player_speed >> 7);
        if (game_active && pickup_ok)            score_sum = score_sum + 16'(PICKUP_SCORE);
        score_d = sat_to(score_sum, SCORE_CEIL);

        // pickup lands first so a same-cycle tick drains the refilled value
        fuel_up  = {2'b00, fuel_q} + (pickup_ok ? 16'(FUEL_PICKUP) : 16'd0);
        fuel_mid = sat_to(fuel_up, 14'(FUEL_MAX));
        fuel_d   = fuel_mid;
        if (game_active && fuel_tick && moving && (fuel_mid != 14'd0)) fuel_d = fuel_mid - 14'd1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (fuel_d <= 14'(FUEL_LOW)) state_d = LOW;
            LOW: begin
                if (fuel_d == 14'd0)              state_d = EMPTY;
                else if (fuel_d > 14'(FUEL_LOW))  state_d = RUN;
            end
            EMPTY:   state_d = EMPTY;
            default: state_d = RUN;
        endcase
    end

    // ---------------- marker placement sequencer ----------------
    seq_state_t                    seq_q, seq_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [N_MARKERS-1:0][10:0]    shadow_q, shadow_d, marker_q, marker_d;
    logic                          shadow_vld_q, shadow_vld_d;
    logic [31:0]                   cur_dist, div_quotient;
    logic [63:0]                   div_dividend;
    logic                          div_start, div_abort, div_done, bypass, last;

    assign cur_dist     = distances[idx_q];
    assign div_dividend = {32'd0, cur_dist} * {32'd0, SPAN_U};
    assign bypass       = (track_length == 32'd0) || (cur_dist >= track_length);
    assign last         = (idx_q == IDX_W'(N_MARKERS - 1));

    always_comb begin
        seq_d        = seq_q;
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        shadow_vld_d = shadow_vld_q;
        marker_d     = marker_q;
        div_start    = 1'b0;
        div_abort    = 1'b0;
        if (frame_start) begin
            // commit only a complete set; an interrupted run is thrown away
            if (shadow_vld_q) marker_d = shadow_q;
            shadow_vld_d = 1'b0;
            div_abort    = 1'b1;
            idx_d        = '0;
            seq_d        = SEQ_ISSUE;
        end else begin
            case (seq_q)
                SEQ_ISSUE: begin
                    if (bypass) begin
                        shadow_d[idx_q] = Y_TOP;
                        if (last) begin
                            shadow_vld_d = 1'b1;
                            seq_d        = SEQ_IDLE;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        div_start = 1'b1;
                        seq_d     = SEQ_WAIT;
                    end
                end
                SEQ_WAIT: begin
                    if (div_done) begin
                        shadow_d[idx_q] = 11'(32'(Y_REST) - div_quotient);
                        if (last) begin
                            shadow_vld_d = 1'b1;
                            seq_d        = SEQ_IDLE;
                        end else begin
                            idx_d = idx_q + 1'b1;
                            seq_d = SEQ_ISSUE;
                        end
                    end
                end
                default: seq_d = SEQ_IDLE;
            endcase
        end
    end

    seq_divider u_div (
        .clk      (clk),
        .resetN   (resetN),
        .start    (div_start),
        .abort    (div_abort),
        .dividend (div_dividend),
        .divisor  (track_length),
        .quotient (div_quotient),
        .done     (div_done)
    );

    // ---------------- pixel pipeline ----------------
    logic [N_MARKERS-1:0] hit_q, hit_d;
    logic                 in_bar_q, in_col, in_rows;
    logic [7:0]           colour_q, colour_d;
    logic                 alert;

    // offset compares wrap below the origin, so one unsigned test covers both bounds
    assign in_col  = (({1'b0, requested_x} - 12'(BAR_X))   < 12'(BAR_W));
    assign in_rows = (({1'b0, requested_y} - 12'(BAR_TOP)) < 12'(BAR_BOTTOM - BAR_TOP));

    always_comb begin
        hit_d = '0;
        for (int i = 0; i < N_MARKERS; i++) begin
            hit_d[i] = in_col && (({1'b0, requested_y} - {1'b0, marker_q[i]}) < 12'(MARKER_H));
        end
    end

    assign alert = (state_q == EMPTY) || ((state_q == LOW) && frame_cnt_q[BLINK_BIT]);

    always_comb begin
        colour_d = MASK;
        if (in_bar_q) colour_d = alert ? ALERT : BAR;
        for (int i = N_MARKERS - 1; i >= 0; i--) begin
            if (hit_q[i]) colour_d = (i == 0) ? MARKER0 : MARKERN;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            frame_cnt_q  <= '0;
            score_q      <= '0;
            fuel_q       <= 14'(FUEL_MAX);
            state_q      <= RUN;
            seq_q        <= SEQ_IDLE;
            idx_q        <= '0;
            shadow_q     <= {N_MARKERS{Y_REST}};
            shadow_vld_q <= 1'b0;
            marker_q     <= {N_MARKERS{Y_REST}};
            hit_q        <= '0;
            in_bar_q     <= 1'b0;
            colour_q     <= MASK;
        end else begin
            frame_cnt_q  <= frame_cnt_d;
            score_q      <= score_d;
            fuel_q       <= fuel_d;
            state_q      <= state_d;
            seq_q        <= seq_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            shadow_vld_q <= shadow_vld_d;
            marker_q     <= marker_d;
            hit_q        <= hit_d;
            in_bar_q     <= in_col && in_rows;
            colour_q     <= colour_d;
        end
    end

    assign output_color = colour_q;
    assign marker_y     = marker_q;
    assign score_val    = score_q;
    assign fuel_val     = fuel_q;
    assign fuel_empty   = (state_q == EMPTY);

endmodule

// File: doc/hud_track_meter.md
# hud_track_meter

Parametrised successor to the single-car progress bar. It renders the left-edge race-progress column for `N_MARKERS` cars, each placed by a sequential divider as distance / track_length. It also owns the saturating score and fuel counters and a low-fuel state machine that blinks the bar. It sits in the VGA object layer beside the other sprite controllers and returns one 8-bit colour per requested pixel.

## Interface
Parameters:
- `N_MARKERS`, 2: number of cars shown; marker 0 has the highest draw priority.
- `BAR_X`, 0: left x of the bar column.
- `BAR_W`, 32: width of the bar column.
- `BAR_TOP`, 16: top y of the bar column.
- `BAR_BOTTOM`, 480: bottom y of the bar column (exclusive).
- `MARKER_H`, 16: marker height; marker width is `BAR_W`.
- `FUEL_MAX`, 100: fuel ceiling.
- `FUEL_PICKUP`, 5: fuel added per pickup.
- `PICKUP_SCORE`, 100: score added per pickup.
- `FUEL_LOW`, 20: LOW threshold.
- `SCORE_PERIOD`, 16: frames per score tick; must be a power of 2.
- `FUEL_PERIOD`, 64: frames per fuel tick; must be a power of 2.
- `BLINK_PERIOD`, 16: frames per blink phase; must be a power of 2.

Ports:
- `clk`  in  1  system clock
- `resetN`  in  1  asynchronous, active-low reset
- `frame_start`  in  1  one-cycle pulse per frame
- `game_active`  in  1  counters advance only while high
- `requested_x`  in  11  pixel x
- `requested_y`  in  11  pixel y
- `player_speed`  in  10  player speed
- `fuel_pickup`  in  1  one-cycle pulse
- `distances`  in  `N_MARKERS`×32  unsigned distance per car
- `track_length`  in  32  unsigned track length
- `output_color`  out  8  pixel colour; 8'h62 = transparent
- `marker_y`  out  `N_MARKERS`×11  committed marker top y
- `score_val`  out  14  score
- `fuel_val`  out  14  fuel
- `fuel_empty`  out  1  high in state EMPTY

## Operation
- Reset values:
  - `output_color` = 8'h62, `score_val` = 0, `fuel_val` = `FUEL_MAX`, `fuel_empty` = 0.
  - Every `marker_y` = `BAR_BOTTOM` − `MARKER_H`.
  - FSM = RUN, frame counter = 0, divider = IDLE.
- Frame counter: 16 bits, increments on every `frame_start`. A tick for a period P fires when the post-increment value mod P == 0.
- Score:
  - On a `SCORE_PERIOD` tick with `game_active` and `player_speed` > 0: add `player_speed` >> 7.
  - On `fuel_pickup` with `game_active`: add `PICKUP_SCORE`.
  - Score saturates at 9999 and never wraps.
- Fuel:
  - On `fuel_pickup`: fuel = min(fuel + `FUEL_PICKUP`, `FUEL_MAX`).
  - On a `FUEL_PERIOD` tick with `player_speed` > 0: fuel decrements by 1, saturating at 0.
  - If both occur in the same cycle, the pickup is applied before the decrement.
- Fuel FSM:
  - RUN → LOW when fuel ≤ `FUEL_LOW`.
  - LOW → RUN when fuel > `FUEL_LOW`.
  - LOW → EMPTY when fuel == 0.
  - EMPTY is left only by reset. In EMPTY, `fuel_pickup` is ignored and `fuel_empty` = 1.
- Marker placement:
  - On `frame_start`, the divider starts for marker 0. The markers are then processed sequentially.
  - SPAN = `BAR_BOTTOM` − `BAR_TOP` − `MARKER_H`.
  - Each marker's y = `BAR_BOTTOM` − `MARKER_H` − (d × SPAN) / `track_length`, computed with a 32-step restoring divide.
  - If d ≥ `track_length` or `track_length` == 0, the result is `BAR_TOP` and no divide is run.
  - Results go to shadow registers. All `marker_y` values commit together on the next `frame_start`, so a frame never mixes old and new positions.
  - A `frame_start` arriving while the divider is busy aborts the run. The shadows are discarded and a new run starts.
- Pixel colour, in priority order:
  1. The lowest-index marker whose rectangle contains the pixel: 8'he4 for marker 0, 8'h1f for all other markers.
  2. Inside the bar column: 8'h6d. In LOW, this alternates with 8'he0 every `BLINK_PERIOD` frames. In EMPTY, it is 8'he0 steadily.
  3. Otherwise: 8'h62.
- Pixel colouring ignores `game_active`.

## Timing
- `output_color` latency is 2 cycles from `requested_x`/`requested_y`:
  - Stage 1 registers hit flags.
  - Stage 2 registers the resolved colour.
- Counters, `score_val`, `fuel_val` and `fuel_empty` update 1 cycle after the event cycle.
- Divider run length: (32 + 2) cycles per marker, so `N_MARKERS` × 34 cycles per run, well under one frame.
- Deasserting `resetN` mid-divide clears all state immediately.

## Structure
- Package `hud_pkg`:
  - FSM enum `fuel_state_t` {RUN, LOW, EMPTY}.
  - Colour constants MASK (8'h62), BAR (8'h6d), ALERT (8'he0), and the marker colours.
  - The 9999 score ceiling.
- Sub-module `seq_divider`, 32-bit unsigned restoring divider:
  - Inputs: `start`, `abort`, `dividend`, `divisor`.
  - Outputs: `quotient`, `done`.
  - Instantiated once and time-shared across markers.

## Test plan
- Reset, then hold `player_speed` = 256 with `game_active` = 1 for 64 frames → `score_val` = 8, `fuel_val` = 99, FSM in RUN.
- Fuel at 98, pulse `fuel_pickup` → `fuel_val` = 100 (saturates, no wrap), `score_val` increases by 100.
- Fuel at 1 with a `FUEL_PERIOD` tick and a pickup in the same cycle → fuel = 5, FSM in LOW. Drain fuel to 0 → `fuel_empty` = 1. Further pickups leave fuel at 0.
- `track_length` = 1000, d0 = 500, d1 = 2000, defaults → after two `frame_start` pulses, `marker_y[0]` = 240 and `marker_y[1]` = 16.
- Markers overlapping at pixel (5, 240) → `output_color` = 8'he4 two cycles later. Pixel (40, 240) → 8'h62. Pixel (5, 100) in LOW → alternates 8'h6d and 8'he0 every 16 frames.
- Assert `resetN` mid-divide → all outputs return to reset values on the same edge.
